// File: rtl/usb_tx_byte_serializer_if.sv
// Byte handshake and line-side signals between the TX packet controller
// (master) and the USB TX byte serializer (slave).
interface usb_tx_byte_serializer_if;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_last;
    logic       tx_byte_ready;
    logic       tx_busy;
    logic       tx_error;
    logic       dp;
    logic       dm;

    modport master (
        output tx_byte, tx_byte_valid, tx_byte_last,
        input  tx_byte_ready, tx_busy, tx_error, dp, dm
    );

    modport slave (
        input  tx_byte, tx_byte_valid, tx_byte_last,
        output tx_byte_ready, tx_busy, tx_error, dp, dm
    );
endinterface

// File: rtl/usb_tx_byte_serializer.sv
// USB TX byte serializer: shifts bytes out LSB first, inserts a stuffed 0
// after STUFF_LIMIT consecutive data 1s (run spans byte boundaries), NRZI
// encodes onto D+/D- and closes the packet with SE0 x2 bit periods + J.
module usb_tx_byte_serializer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    usb_tx_byte_serializer_if.slave        bus
);
    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int                ONES_W   = $clog2(STUFF_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_STUFF,
        S_EOP_SE0,
        S_EOP_J
    } state_e;

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  clk_cnt_q,  clk_cnt_d;
    logic [ONES_W-1:0] ones_cnt_q, ones_cnt_d;
    logic [2:0]        bit_idx_q,  bit_idx_d;
    logic [7:0]        shreg_q,    shreg_d;
    logic              last_q,     last_d;
    logic              byte_end_q, byte_end_d;   // pending stuff bit closes the byte
    logic              eop_cnt_q,  eop_cnt_d;    // SE0 bit period counter
    logic              dp_q,       dp_d;
    logic              dm_q,       dm_d;
    logic              busy_q,     busy_d;
    logic              ready_q,    ready_d;
    logic              error_q,    error_d;

    logic              boundary;
    logic              do_byte_end;
    logic [ONES_W-1:0] ones_next;

    // NRZI: a 0 swaps J<->K, a 1 holds the current line state.
    function automatic logic [1:0] nrzi(input logic bit_v, input logic cur_dp, input logic cur_dm);
        return bit_v ? {cur_dp, cur_dm} : {cur_dm, cur_dp};
    endfunction

    // Next-state, bit timing, stuffing and line encoding.
    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path infers a latch.
        state_d     = state_q;
        ones_cnt_d  = ones_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        last_d      = last_q;
        byte_end_d  = byte_end_q;
        eop_cnt_d   = eop_cnt_q;
        dp_d        = dp_q;
        dm_d        = dm_q;
        busy_d      = busy_q;
        ready_d     = 1'b0;
        error_d     = 1'b0;
        do_byte_end = 1'b0;
        ones_next   = '0;

        boundary  = (clk_cnt_q == CNT_MAX);
        clk_cnt_d = (state_q == S_IDLE || boundary) ? '0 : clk_cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (bus.tx_byte_valid) begin
                    state_d      = S_SHIFT;
                    shreg_d      = bus.tx_byte;
                    last_d       = bus.tx_byte_last;
                    bit_idx_d    = 3'd0;
                    ones_cnt_d   = '0;
                    busy_d       = 1'b1;
                    ready_d      = 1'b1;
                    {dp_d, dm_d} = nrzi(bus.tx_byte[0], dp_q, dm_q);
                end
            end
            S_SHIFT: begin
                if (boundary) begin
                    ones_next = shreg_q[0] ? ones_cnt_q + ONES_W'(1) : '0;
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (ones_next == ONES_MAX) begin
                        state_d      = S_STUFF;
                        ones_cnt_d   = '0;
                        byte_end_d   = (bit_idx_q == 3'd7);
                        {dp_d, dm_d} = nrzi(1'b0, dp_q, dm_q);
                    end else begin
                        ones_cnt_d = ones_next;
                        if (bit_idx_q == 3'd7) begin
                            do_byte_end = 1'b1;
                        end else begin
                            {dp_d, dm_d} = nrzi(shreg_q[1], dp_q, dm_q);
                        end
                    end
                end
            end
            S_STUFF: begin
                if (boundary) begin
                    state_d = S_SHIFT;
                    if (byte_end_q) begin
                        do_byte_end = 1'b1;
                    end else begin
                        {dp_d, dm_d} = nrzi(shreg_q[0], dp_q, dm_q);
                    end
                end
            end
            S_EOP_SE0: begin
                if (boundary) begin
                    if (eop_cnt_q) begin
                        state_d   = S_EOP_J;
                        eop_cnt_d = 1'b0;
                        dp_d      = 1'b1;
                        dm_d      = 1'b0;
                    end else begin
                        eop_cnt_d = 1'b1;
                    end
                end
            end
            S_EOP_J: begin
                if (boundary) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // End of bit7 (plus any stuff bit): finish the packet, chain the next
        // byte with no gap, or flag an underrun. The ones run is carried over.
        if (do_byte_end) begin
            if (last_q) begin
                state_d   = S_EOP_SE0;
                eop_cnt_d = 1'b0;
                dp_d      = 1'b0;
                dm_d      = 1'b0;
            end else if (bus.tx_byte_valid) begin
                state_d      = S_SHIFT;
                shreg_d      = bus.tx_byte;
                last_d       = bus.tx_byte_last;
                bit_idx_d    = 3'd0;
                ready_d      = 1'b1;
                {dp_d, dm_d} = nrzi(bus.tx_byte[0], dp_q, dm_q);
            end else begin
                state_d   = S_EOP_SE0;
                eop_cnt_d = 1'b0;
                error_d   = 1'b1;
                dp_d      = 1'b0;
                dm_d      = 1'b0;
            end
        end
    end

    // State and registered outputs; reset drops the line straight to J.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            ones_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            last_q     <= 1'b0;
            byte_end_q <= 1'b0;
            eop_cnt_q  <= 1'b0;
            dp_q       <= 1'b1;
            dm_q       <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            byte_end_q <= byte_end_d;
            eop_cnt_q  <= eop_cnt_d;
            dp_q       <= dp_d;
            dm_q       <= dm_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    assign bus.tx_byte_ready = ready_q;
    assign bus.tx_busy       = busy_q;
    assign bus.tx_error      = error_q;
    assign bus.dp            = dp_q;
    assign bus.dm            = dm_q;
endmodule

// File: tb/tb_usb_tx_byte_serializer.sv
// Bench for usb_tx_byte_serializer: directed packets plus random packets,
// each compared cycle by cycle against a bit-level reference model.
module tb_usb_tx_byte_serializer;
    localparam int CPB = 4;
    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    usb_tx_byte_serializer_if bus ();

    usb_tx_byte_serializer #(.CLKS_PER_BIT(CPB), .STUFF_LIMIT(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] pkt_bytes[$];
    bit         pkt_underrun;
    logic [3:0] exp_trace[$];   // {dp, dm, ready, error} per clock cycle
    logic [3:0] got_trace[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: data bits LSB first, a 0 after every 6th consecutive data 1,
    // NRZI from J, then SE0 SE0 J; each bit period is CPB cycles.
    function automatic void build_model();
        logic [1:0] per[$];
        int         rdy_per[$];
        int         err_per;
        logic [1:0] lvl;
        int         ones;
        logic [7:0] b;
        per.delete();
        rdy_per.delete();
        err_per = -1;
        lvl  = LJ;
        ones = 0;
        foreach (pkt_bytes[k]) begin
            rdy_per.push_back(per.size());
            b = pkt_bytes[k];
            for (int i = 0; i < 8; i++) begin
                if (!b[i]) lvl = (lvl == LJ) ? LK : LJ;
                per.push_back(lvl);
                ones = b[i] ? ones + 1 : 0;
                if (ones == 6) begin
                    lvl = (lvl == LJ) ? LK : LJ;
                    per.push_back(lvl);
                    ones = 0;
                end
            end
        end
        if (pkt_underrun) err_per = per.size();
        per.push_back(LSE0);
        per.push_back(LSE0);
        per.push_back(LJ);
        exp_trace.delete();
        foreach (per[p]) begin
            for (int c = 0; c < CPB; c++) begin
                exp_trace.push_back({per[p], (c == 0 && (p inside {rdy_per})), (c == 0 && p == err_per)});
            end
        end
    endfunction

    // Drive one packet, record the line until tx_busy falls, compare with the model.
    // abort_at >= 0 asserts rst at that cycle instead and checks the async reset.
    task automatic run_pkt(input string tag, input int abort_at);
        int n;
        int idx;
        bit timed_out;
        build_model();
        got_trace.delete();
        @(negedge clk);
        bus.tx_byte       = pkt_bytes[0];
        bus.tx_byte_last  = (pkt_bytes.size() == 1) && !pkt_underrun;
        bus.tx_byte_valid = 1'b1;
        n = 0;
        idx = 0;
        timed_out = 1'b0;
        forever begin
            @(negedge clk);
            if (abort_at >= 0 && n == abort_at) begin
                check({tag, " busy_before_rst"}, bus.tx_busy, 1'b1);
                rst = 1'b1;
                bus.tx_byte_valid = 1'b0;
                #1;
                check({tag, " rst_line"}, {bus.dp, bus.dm}, LJ);
                check({tag, " rst_busy"}, bus.tx_busy, 1'b0);
                check({tag, " rst_ready_err"}, {bus.tx_byte_ready, bus.tx_error}, 2'b00);
                return;
            end
            if (!bus.tx_busy) break;
            got_trace.push_back({bus.dp, bus.dm, bus.tx_byte_ready, bus.tx_error});
            if (bus.tx_byte_ready) begin
                idx++;
                if (idx < pkt_bytes.size()) begin
                    bus.tx_byte      = pkt_bytes[idx];
                    bus.tx_byte_last = (idx == pkt_bytes.size() - 1) && !pkt_underrun;
                end else begin
                    bus.tx_byte_valid = 1'b0;
                end
            end
            n++;
            if (n > 2000) begin
                timed_out = 1'b1;
                break;
            end
        end
        bus.tx_byte_valid = 1'b0;
        check({tag, " timeout"}, timed_out, 1'b0);
        check({tag, " cycles"}, got_trace.size(), exp_trace.size());
        for (int i = 0; i < got_trace.size() && i < exp_trace.size(); i++) begin
            tests++;
            assert (got_trace[i] === exp_trace[i]) else begin
                fails++;
                $error("FAIL %s cyc%0d {dp,dm,rdy,err}: got %b expected %b", tag, i, got_trace[i], exp_trace[i]);
                break;
            end
        end
        check({tag, " idle_line"}, {bus.dp, bus.dm, bus.tx_byte_ready, bus.tx_error}, {LJ, 2'b00});
    endtask

    initial begin
        bus.tx_byte       = 8'h00;
        bus.tx_byte_valid = 1'b0;
        bus.tx_byte_last  = 1'b0;
        pkt_underrun      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset line", {bus.dp, bus.dm}, LJ);
        check("reset flags", {bus.tx_busy, bus.tx_byte_ready, bus.tx_error}, 3'b000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle no valid", {bus.dp, bus.dm, bus.tx_busy}, {LJ, 1'b0});

        // single 0x80, last
        pkt_bytes = '{8'h80};
        pkt_underrun = 1'b0;
        run_pkt("s1_80", -1);

        // six ones then stuff, then 0,0
        pkt_bytes = '{8'h3F};
        run_pkt("s2_3F", -1);

        // ones run crossing byte boundary
        pkt_bytes = '{8'hE0, 8'h07};
        run_pkt("s3_E0_07", -1);

        // long ones runs
        pkt_bytes = '{8'hFF, 8'hFF};
        run_pkt("s4_FF_FF", -1);

        // stuff bit due right after the final data bit, sent before EOP
        pkt_bytes = '{8'hFC};
        run_pkt("s4b_FC", -1);

        // underrun
        pkt_bytes = '{8'h80};
        pkt_underrun = 1'b1;
        run_pkt("s5_underrun", -1);
        pkt_underrun = 1'b0;

        // reset mid-packet during bit3, then scenario 1 again
        pkt_bytes = '{8'h80};
        run_pkt("s6_abort", 3 * CPB + 1);
        repeat (2) @(negedge clk);
        check("s6 held line", {bus.dp, bus.dm, bus.tx_busy}, {LJ, 1'b0});
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_pkt("s6_rerun", -1);

        // random packets with bias toward 0xFF to exercise stuffing
        for (int r = 0; r < 20; r++) begin
            int len;
            pkt_bytes.delete();
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                pkt_bytes.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            end
            pkt_underrun = ($urandom_range(0, 4) == 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_pkt($sformatf("rnd%0d", r), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
